// File: rtl/apb_mst_bridge.sv
// ============================================================================
// Module  : apb_mst_bridge
// Brief   : Single-outstanding APB4 requester with wait-state timeout and
//           local alignment check, fed by a valid/ready command stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_mst_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    output logic                      PRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic [ADDR_WIDTH-1:0]     PADDR,
    output logic                      PWRITE,
    output logic [DATA_WIDTH-1:0]     PWDATA,
    output logic [DATA_WIDTH/8-1:0]   PSTRB,
    input  logic                      PREADY,
    input  logic [DATA_WIDTH-1:0]     PRDATA,
    input  logic                      PSLVERR
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic                  TO_EN      = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] wait_d;
    logic             misalign_w;
    logic             timeout_w;

    assign PRESETn    = ~PRESET;
    assign cmd_ready  = (state_q == ST_IDLE);
    assign misalign_w = |(cmd_addr & ALIGN_MASK);
    assign wait_d     = (wait_q == CNT_MAX) ? wait_q : wait_q + 1'b1;
    // This wait cycle is the last one allowed; PREADY on the same edge still wins.
    assign timeout_w  = TO_EN && !PREADY && (wait_q == CNT_LAST);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (misalign_w) begin
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                            state_q     <= ST_RESP;
                        end else begin
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            PADDR   <= cmd_addr;
                            PWRITE  <= cmd_write;
                            PWDATA  <= cmd_write ? cmd_wdata : '0;
                            PSTRB   <= cmd_write ? cmd_strb : '0;
                            wait_q  <= '0;
                            state_q <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state_q <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        state_q     <= ST_RESP;
                    end else if (timeout_w) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state_q     <= ST_RESP;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_mst_bridge.sv
// ============================================================================
// Module  : tb_apb_mst_bridge
// Brief   : Self-checking bench for apb_mst_bridge with an APB slave model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb_mst_bridge;

    localparam int TO = 16;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int total = 0;
    int bad   = 0;

    always #5 PCLK = ~PCLK;

    apb_mst_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PREADY      (PREADY),
        .PRDATA      (PRDATA),
        .PSLVERR     (PSLVERR)
    );

    // One complete command: the slave holds PREADY low for `waits` ACCESS
    // cycles, then completes with slverr/rdata. Expected results follow the
    // bridge's rules directly: misalignment, timeout after TO waits, else slave.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int waits, input logic slverr,
                           input logic [31:0] rdata, input int rsp_delay, input string name);
        logic        misal;
        logic        exp_to;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_acc;
        int          acc;
        logic [68:0] exp_bus;
        logic [33:0] exp_rsp;
        misal     = (addr[1:0] != 2'b00);
        exp_to    = !misal && (waits >= TO);
        exp_err   = misal || exp_to || slverr;
        exp_rdata = (!misal && !exp_to && !wr) ? rdata : 32'h0;
        exp_acc   = exp_to ? TO : waits + 1;
        exp_bus   = {addr, wr, (wr ? strb : 4'h0), (wr ? wdata : 32'h0)};
        exp_rsp   = {exp_err, exp_to, exp_rdata};

        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s idle_ready: got %b want 1", name, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);

        if (!misal) begin
            total++;
            if ({PSEL, PENABLE, rsp_valid, PADDR, PWRITE, PSTRB, PWDATA} !== {3'b100, exp_bus}) begin
                bad++;
                $display("FAIL %s setup: got sel=%b en=%b rv=%b bus=%h want sel=1 en=0 rv=0 bus=%h",
                         name, PSEL, PENABLE, rsp_valid, {PADDR, PWRITE, PSTRB, PWDATA}, exp_bus);
            end
            acc = 0;
            @(negedge PCLK);
            while (PSEL === 1'b1 && PENABLE === 1'b1 && acc <= 40) begin
                total++;
                if ({rsp_valid, PADDR, PWRITE, PSTRB, PWDATA} !== {1'b0, exp_bus}) begin
                    bad++;
                    $display("FAIL %s access_hold[%0d]: got rv=%b bus=%h want rv=0 bus=%h",
                             name, acc, rsp_valid, {PADDR, PWRITE, PSTRB, PWDATA}, exp_bus);
                end
                PREADY  = (acc >= waits);
                PRDATA  = (acc >= waits) ? rdata : $urandom;
                PSLVERR = (acc >= waits) ? slverr : 1'($urandom);
                acc++;
                @(negedge PCLK);
            end
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            total++;
            if (acc !== exp_acc || PSEL !== 1'b0 || PENABLE !== 1'b0) begin
                bad++;
                $display("FAIL %s access_len: got cycles=%0d sel=%b en=%b want cycles=%0d sel=0 en=0",
                         name, acc, PSEL, PENABLE, exp_acc);
            end
        end else begin
            total++;
            if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
                bad++;
                $display("FAIL %s misaligned_no_bus: got sel=%b en=%b want 0 0", name, PSEL, PENABLE);
            end
        end

        total++;
        if (rsp_valid !== 1'b1 || {rsp_err, rsp_timeout, rsp_rdata} !== exp_rsp) begin
            bad++;
            $display("FAIL %s response: got rv=%b err/to/data=%h want rv=1 err/to/data=%h",
                     name, rsp_valid, {rsp_err, rsp_timeout, rsp_rdata}, exp_rsp);
        end
        for (int i = 0; i < rsp_delay; i++) begin
            @(negedge PCLK);
            total++;
            if ({rsp_valid, cmd_ready, PSEL, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, exp_rsp}) begin
                bad++;
                $display("FAIL %s rsp_hold[%0d]: got rv=%b rdy=%b sel=%b rsp=%h want rv=1 rdy=0 sel=0 rsp=%h",
                         name, i, rsp_valid, cmd_ready, PSEL, {rsp_err, rsp_timeout, rsp_rdata}, exp_rsp);
            end
        end
        rsp_ready = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s rsp_done: got rv=%b rdy=%b want rv=0 rdy=1", name, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB} !== 71'h0) begin
            bad++;
            $display("FAIL reset_bus: got %h want 0", {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB});
        end
        total++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== 35'h0) begin
            bad++;
            $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata});
        end
        total++;
        if (PRESETn !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ctl: got presetn=%b rdy=%b want 0 1", PRESETn, cmd_ready);
        end
        PRESET = 1'b0;
        #1;
        total++;
        if (PRESETn !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got presetn=%b want 1", PRESETn);
        end
        @(negedge PCLK);
    endtask

    task automatic test_write();
        do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 0, "write_basic");
        do_xfer(1'b1, 32'h24, 32'h12345678, 4'h5, 1, 1'b0, 32'h0, 1, "write_strb5");
    endtask

    task automatic test_read_wait();
        do_xfer(1'b0, 32'h10, $urandom, 4'hF, 3, 1'b0, 32'hDEADBEEF, 0, "read_wait3");
    endtask

    task automatic test_slverr();
        do_xfer(1'b0, 32'h8, $urandom, 4'hF, 0, 1'b1, $urandom, 0, "read_slverr");
        do_xfer(1'b1, 32'hC, $urandom, 4'h3, 2, 1'b1, $urandom, 0, "write_slverr");
    endtask

    task automatic test_timeout();
        do_xfer(1'b0, 32'h30, $urandom, 4'hF, 1000, 1'b0, $urandom, 0, "timeout_stuck");
        do_xfer(1'b0, 32'h34, $urandom, 4'hF, 2, 1'b0, $urandom, 0, "after_timeout");
        do_xfer(1'b0, 32'h38, $urandom, 4'hF, TO - 1, 1'b0, $urandom, 0, "waits_15");
        do_xfer(1'b1, 32'h3C, $urandom, 4'hF, TO, 1'b0, $urandom, 0, "waits_16");
    endtask

    task automatic test_misaligned();
        do_xfer(1'b0, 32'h13, $urandom, 4'hF, 0, 1'b0, $urandom, 5, "misaligned_13");
        do_xfer(1'b1, 32'h42, $urandom, 4'hF, 0, 1'b0, $urandom, 0, "misaligned_42");
    endtask

    task automatic test_reset_mid_access();
        PREADY    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h40;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        total++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: got sel=%b en=%b want 1 1", PSEL, PENABLE);
        end
        #2 PRESET = 1'b1;
        #1;
        total++;
        if ({PSEL, PENABLE, rsp_valid, PRESETn} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid_async: got sel/en/rv/presetn=%b want 0000", {PSEL, PENABLE, rsp_valid, PRESETn});
        end
        @(negedge PCLK);
        PRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            total++;
            if ({PSEL, rsp_valid, cmd_ready} !== 3'b001) begin
                bad++;
                $display("FAIL rst_mid_quiet[%0d]: got sel/rv/rdy=%b want 001", i, {PSEL, rsp_valid, cmd_ready});
            end
        end
        do_xfer(1'b0, 32'h44, $urandom, 4'hF, 2, 1'b0, $urandom, 0, "read_after_reset");
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        int nrsp;
        int cyc;
        nrsp      = 0;
        cyc       = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h20;
        rsp_ready = 1'b1;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        PRDATA    = $urandom;
        while (acc_cyc.size() < 4 && cyc < 40) begin
            if (cmd_ready === 1'b1) acc_cyc.push_back(cyc);
            if (rsp_valid === 1'b1) nrsp++;
            @(negedge PCLK);
            cyc++;
        end
        cmd_valid = 1'b0;
        while (cmd_ready !== 1'b1 && cyc < 80) begin
            if (rsp_valid === 1'b1) nrsp++;
            @(negedge PCLK);
            cyc++;
        end
        PREADY    = 1'b0;
        rsp_ready = 1'b0;
        total++;
        if (acc_cyc.size() != 4 || nrsp != 4) begin
            bad++;
            $display("FAIL b2b_count: got accepts=%0d rsps=%0d want 4 4", acc_cyc.size(), nrsp);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (acc_cyc[i+1] - acc_cyc[i] != 4) begin
                    bad++;
                    $display("FAIL b2b_gap[%0d]: got %0d cycles want 4", i, acc_cyc[i+1] - acc_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          waits;
        int          r;
        for (int n = 0; n < 30; n++) begin
            addr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) addr = addr | 32'($urandom_range(1, 3));
            r = $urandom_range(0, 9);
            if (r < 7)       waits = $urandom_range(0, 4);
            else if (r == 7) waits = TO - 1;
            else if (r == 8) waits = TO;
            else             waits = $urandom_range(TO + 1, TO + 9);
            do_xfer(1'($urandom), addr, $urandom, 4'($urandom), waits,
                    ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        PSLVERR   = 1'b0;
        repeat (2) @(negedge PCLK);
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_misaligned();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_mst_bridge.md
Name: apb_mst_bridge

Overview:
- Single-outstanding APB4 requester: converts a valid/ready command stream into APB SETUP/ACCESS transfers toward the APB memory slave (apb_dpmem).
- Returns read data and error status on a valid/ready response stream.
- Adds a PREADY wait-state timeout and a local alignment check, so a hung or misaddressed access never stalls the command source.

Parameters:
- ADDR_WIDTH, 32, PADDR / cmd_addr width.
- DATA_WIDTH, 32, data width; must be 8, 16 or 32. Strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  system clock
- PRESET  in  1  asynchronous active-high reset
- PRESETn  out  1  ~PRESET, combinational, forwarded to the APB slave
- cmd_valid  in  1  command request
- cmd_ready  out  1  bridge accepts command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte lanes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and aborts)
- rsp_err  out  1  PSLVERR, misalignment or timeout
- rsp_timeout  out  1  error cause is timeout
- PSEL  out  1  slave select
- PENABLE  out  1  access phase
- PADDR  out  ADDR_WIDTH  address
- PWRITE  out  1  direction
- PWDATA  out  DATA_WIDTH  write data
- PSTRB  out  DATA_WIDTH/8  strobes
- PREADY  in  1  slave ready
- PRDATA  in  DATA_WIDTH  read data
- PSLVERR  in  1  slave error

Behaviour:
- All outputs are registered except PRESETn and cmd_ready, which are decoded from state.
- While PRESET is high, all registered outputs are 0 and state is IDLE; this takes effect immediately and asynchronously.
- State machine: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch the command.
  - If cmd_addr[log2(DATA_WIDTH/8)-1:0] != 0, skip the bus and go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL=1, PENABLE=0.
  - PADDR, PWRITE and PWDATA come from the latched command.
  - PSTRB = latched strb for writes, 0 for reads; PWDATA = 0 for reads.
  - Always goes to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; address, control and data held stable.
  - On a PCLK edge with PREADY=1:
    - capture PRDATA into rsp_rdata for reads only;
    - rsp_err = PSLVERR; rsp_timeout = 0;
    - drop PSEL and PENABLE; go to RESP.
  - Wait counter: cleared on SETUP entry, +1 each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES (if nonzero):
    - drop PSEL and PENABLE; go to RESP;
    - rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - Counter width is clog2(TIMEOUT_CYCLES+1) and saturates.
  - A PREADY=1 arriving on the same edge as the timeout wins (normal completion).
- RESP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On the rsp_ready handshake, clear rsp_valid and go to IDLE.
  - cmd_ready = 0 throughout, so no overlap of commands.
- PADDR, PWRITE, PSTRB and PWDATA hold their last values when PSEL=0; only PSEL and PENABLE return to 0.
- Minimum latency with zero wait states: accept at edge N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3. Throughput is 1 transfer per 4 cycles when rsp_ready is tied high.
- rsp_err for a read error still reports PRDATA in rsp_rdata (slave-defined contents).
- PRESET asserted mid-ACCESS: PSEL and PENABLE drop immediately; the command is lost and no response is generated.
- Protocol invariants:
  - PENABLE=1 only when PSEL=1.
  - PENABLE rises exactly one cycle after PSEL rises.
  - No PSEL=1 cycles without a preceding accepted command.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, strb 0xF, PREADY=1 → SETUP one cycle (PSEL=1, PENABLE=0), ACCESS one cycle, rsp_valid at accept+3 with rsp_err=0, rsp_rdata=0.
- Read 0x10 with PREADY low for 3 ACCESS cycles, then PRDATA=0xDEADBEEF → PSTRB=0 throughout, PADDR stable 4 ACCESS cycles, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Read with PSLVERR=1 when PREADY=1 → rsp_err=1, rsp_timeout=0.
- TIMEOUT_CYCLES=16, PREADY stuck 0 → PSEL drops after 16 wait cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Then issue the next command normally.
- cmd_addr=0x13 → no PSEL pulse, rsp_valid one cycle after accept with rsp_err=1. Also: rsp_ready held low 5 cycles → rsp_* stable and cmd_ready=0 until the handshake.
- PRESET pulsed during ACCESS → PSEL, PENABLE, rsp_valid = 0 immediately, no response issued; after release the next read completes correctly.
